// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART types and constants for the transmit and receive side.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FRAME_CYCLES = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } uart_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Single-clock byte FIFO with registered occupancy; DEPTH power of 2.
// Revision : 1.0
// ============================================================================
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] push_data,
  input  logic                   push,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] pop_data,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   empty
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO plus frame-pacing FSM feeding the UART serializer.
//            Define UART_TX_LEVEL_EN to expose the FIFO occupancy on `level`.
// Revision : 1.0
// ============================================================================
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter  int GAP_CYCLES   = 2,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [UART_DATA_W-1:0] ser_data,
  output logic                   ser_hold,
  output logic                   busy,
`ifdef UART_TX_LEVEL_EN
  output logic [AW:0]            level,
`endif
  output logic                   empty,
  output logic                   full
);

  localparam int c_CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_SEND_LAST = c_CNT_W'(FRAME_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);

  uart_tx_state_e         r_state;
  uart_tx_state_e         w_next_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [UART_DATA_W-1:0] r_ser_data;
  logic                   r_ser_hold;
  logic [UART_DATA_W-1:0] w_head;
  logic [AW:0]            w_count;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data (wr_data),
    .push      (wr_valid),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // IDLE is always visited between frames, so a frame period is FRAME+GAP+2.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: w_next_state = ST_SEND;
      ST_SEND: if (r_cnt == c_SEND_LAST) w_next_state = ST_GAP;
      ST_GAP:  if (r_cnt == c_GAP_LAST)  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Counter restarts on every state change; ser_hold is registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ser_data <= '0;
      r_ser_hold <= 1'b1;
    end else begin
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state == ST_SEND || r_state == ST_GAP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_pop) begin
        r_ser_data <= w_head;
      end
      r_ser_hold <= (w_next_state != ST_SEND);
    end
  end

  assign ser_data = r_ser_data;
  assign ser_hold = r_ser_hold;
  assign busy     = (r_state != ST_IDLE);
  assign empty    = w_empty;
  assign full     = w_full;
  assign wr_ready = !w_full;

`ifdef UART_TX_LEVEL_EN
  assign level = w_count;
`else
  logic w_unused_count;
  assign w_unused_count = ^w_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Self-checking bench for uart_tx_feeder (timing model + directed tests).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 11;
  localparam int GAP   = 2;
  localparam int AW    = 4;
  localparam int PER   = FRAME + GAP + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] ser_data;
  logic       ser_hold;
  logic       busy;
  logic       empty;
  logic       full;
`ifdef UART_TX_LEVEL_EN
  logic [AW:0] level;
`endif

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .FRAME_CYCLES (FRAME),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .ser_data (ser_data),
    .ser_hold (ser_hold),
    .busy     (busy),
`ifdef UART_TX_LEVEL_EN
    .level    (level),
`endif
    .empty    (empty),
    .full     (full)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 'h%0h want 'h%0h", name, act, exp);
    end
  endtask

  // Model: queue of accepted bytes plus the edge index of the last pop.
  // A pop happens on any edge with data queued, at least PER edges after the
  // previous pop; hold is low on edges p+1..p+FRAME, busy on edges p..p+FRAME+GAP.
  logic [7:0] mq[$];
  int         cyc = 0;
  int         p_last = -1000;
  logic [7:0] m_data = 8'h00;
  logic       prev_hold = 1'b1;
  logic [7:0] fr_data[$];
  int         fr_time[$];
  logic       s_rst, s_v, m_hold, m_busy, m_full, m_empty;
  logic [7:0] s_d;
  int         occ;

  initial forever begin
    @(posedge clk);
    s_rst = rst;
    s_v   = wr_valid;
    s_d   = wr_data;
    cyc++;
    if (s_rst) begin
      mq.delete();
      p_last = -1000;
      m_data = 8'h00;
    end else begin
      occ = mq.size();
      if (cyc >= p_last + PER && occ > 0) begin
        m_data = mq.pop_front();
        p_last = cyc;
      end
      if (s_v && occ < DEPTH) mq.push_back(s_d);
    end
    #1;
    m_hold  = !(cyc >= p_last + 1 && cyc <= p_last + FRAME);
    m_busy  = (cyc >= p_last && cyc <= p_last + FRAME + GAP);
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    chk("cycle{rdy,hold,busy,empty,full,data}",
        {19'd0, wr_ready, ser_hold, busy, empty, full, ser_data},
        {19'd0, !m_full, m_hold, m_busy, m_empty, m_full, m_data});
`ifdef UART_TX_LEVEL_EN
    chk("cycle_level", {27'd0, level}, mq.size());
`endif
    if (prev_hold === 1'b1 && ser_hold === 1'b0) begin
      fr_data.push_back(ser_data);
      fr_time.push_back(cyc);
    end
    prev_hold = ser_hold;
  end

  task automatic at_edge(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Offers a byte and keeps it offered until accepted; returns just after that edge.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accept_timeout", (n < 200), 1);
    @(posedge clk);
    #2;
  endtask

  task automatic drop();
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    int k = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && k < n) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("wait_idle{busy,empty}", {busy, empty}, 2'b01);
  endtask

  task automatic chk_frames(input string name, input logic [7:0] exp_q[$]);
    chk({name, "_count"}, fr_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < fr_data.size(); i++) begin
      chk($sformatf("%s_byte%0d", name, i), fr_data[i], exp_q[i]);
      if (i > 0) chk($sformatf("%s_period%0d", name, i), fr_time[i] - fr_time[i-1], PER);
    end
  endtask

  logic [7:0] exp_q[$];
  int         t;

  initial begin
    // Reset, with a producer offering data that must be ignored.
    rst = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ser_hold", ser_hold, 1);
    chk("rst_ser_data", ser_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("post_rst_empty", empty, 1);

    // Single byte A5.
    push_byte(8'hA5);
    t = cyc;
    chk("t1_occ", empty, 0);
    drop();
    at_edge(t + 1);
    chk("t1_data", ser_data, 8'hA5);
    chk("t1_load_hold", ser_hold, 1);
    chk("t1_pop_empty", empty, 1);
    at_edge(t + 2);
    chk("t1_hold_fall", ser_hold, 0);
    at_edge(t + 12);
    chk("t1_hold_last_low", ser_hold, 0);
    at_edge(t + 13);
    chk("t1_hold_rise", ser_hold, 1);
    at_edge(t + 14);
    chk("t1_gap_busy", busy, 1);
    at_edge(t + 15);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_empty", empty, 1);

    // Burst 00..0F, FF, F0 with valid held; then EE against a full FIFO.
    at_edge(cyc + 3);
    fr_data.delete();
    fr_time.delete();
    exp_q.delete();
    push_byte(8'h00);
    t = cyc;
    exp_q.push_back(8'h00);
    for (int i = 1; i < 16; i++) begin
      push_byte(8'(i));
      exp_q.push_back(8'(i));
    end
    push_byte(8'hFF);
    push_byte(8'hF0);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hEE);
    chk("t2_edge", cyc - t, 17);
    chk("t2_full", full, 1);
    chk("t2_wr_ready", wr_ready, 0);
    @(negedge clk);
    wr_data = 8'hEE;
    at_edge(t + 30);
    chk("t2_still_full", full, 1);
    at_edge(t + 31);
    chk("t3_pop_when_full", full, 0);
    chk("t3_ready_after_pop", wr_ready, 1);
`ifdef UART_TX_LEVEL_EN
    chk("t3_level15", level, 15);
`endif
    at_edge(t + 32);
    chk("t3_refill", full, 1);
    drop();
    wait_idle(1000);
    chk("t2_first_fall", fr_time.size() > 0 ? fr_time[0] - t : -1, 2);
    chk_frames("t2", exp_q);

    // Push and pop on the same edge at occupancy 1.
    at_edge(cyc + 3);
    fr_data.delete();
    fr_time.delete();
    push_byte(8'h3C);
    t = cyc;
    push_byte(8'hC3);
    drop();
    chk("t4_same_edge_occ", empty, 0);
    at_edge(t + 15);
    chk("t4_never_empty", empty, 0);
    at_edge(t + 16);
    chk("t4_second_pop", ser_data, 8'hC3);
    chk("t4_drained", empty, 1);
    at_edge(t + 17);
    chk("t4_on_schedule", ser_hold, 0);
    wait_idle(200);
    exp_q.delete();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    chk_frames("t4", exp_q);

    // Reset during SEND cycle 5 with three bytes queued.
    at_edge(cyc + 3);
    push_byte(8'h11);
    t = cyc;
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    drop();
    at_edge(t + 7);
    chk("t5_mid_send", ser_hold, 0);
    chk("t5_queued", empty, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("t5_abort_hold", ser_hold, 1);
    chk("t5_abort_data", ser_data, 8'h00);
    chk("t5_abort_empty", empty, 1);
    chk("t5_abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    fr_data.delete();
    fr_time.delete();
    at_edge(cyc + 40);
    chk("t5_no_frame", fr_data.size(), 0);
    push_byte(8'h5A);
    t = cyc;
    drop();
    at_edge(t + 2);
    chk("t5_restart_hold", ser_hold, 0);
    chk("t5_restart_data", ser_data, 8'h5A);
    wait_idle(200);

    // Occupancy while a frame is in flight, then a long run to wrap pointers.
    at_edge(cyc + 3);
    fr_data.delete();
    fr_time.delete();
    exp_q.delete();
    push_byte(8'hC0);
    t = cyc;
    drop();
    at_edge(t + 2);
    for (int i = 1; i <= 5; i++) push_byte(8'hC0 + 8'(i));
    drop();
    at_edge(t + 15);
`ifdef UART_TX_LEVEL_EN
    chk("t6_level5", level, 5);
`endif
    chk("t6_busy_queue", empty, 0);
    at_edge(t + 16);
`ifdef UART_TX_LEVEL_EN
    chk("t6_level4", level, 4);
`endif
    chk("t6_second_byte", ser_data, 8'hC1);
    for (int i = 6; i < 20; i++) push_byte(8'hC0 + 8'(i));
    drop();
    wait_idle(2000);
    for (int i = 0; i < 20; i++) exp_q.push_back(8'hC0 + 8'(i));
    chk_frames("t6", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
